// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and clear-sequencer types for regfile_mp
//
// Purpose : parameter defaults and the clear-FSM state type shared by
//           regfile_mp and regfile_clear_fsm.
// Ports   : none (package).

package regfile_pkg;

  localparam int RF_DW_DEF     = 32;
  localparam int RF_DEPTH_DEF  = 32;
  localparam int RF_NUM_RD_DEF = 2;
  localparam int RF_NUM_RD_MAX = 4;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - clear sequencer that zeroes every register entry
//
// Purpose : walks clr_idx from 0 to DEPTH-1, one entry per cycle, after
//           reset or after a clear request. The sequence always takes
//           exactly DEPTH cycles. Requests that arrive mid-sequence are
//           ignored.
// Ports   :
//   i_clk        clock
//   i_rst        asynchronous active-high reset (restarts the sequence)
//   i_clear_req  single-cycle clear request, honoured only in RF_IDLE
//   o_clear_busy high while in RF_CLEAR
//   o_clr_we     strobe: write zero to entry o_clr_idx at this edge
//   o_clr_idx    entry being cleared this cycle

module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear_req,
  output logic          o_clear_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_e     r_state;
  rf_state_e     w_state_nxt;
  logic [AW-1:0] r_clr_idx;
  logic [AW-1:0] w_clr_idx_nxt;

  // Reset lands in RF_CLEAR so the array is always zeroed before first use.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    o_clr_we      = 1'b0;
    case (r_state)
      RF_IDLE: begin
        if (i_clear_req) begin
          w_state_nxt   = RF_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      RF_CLEAR: begin
        o_clr_we = 1'b1;
        // Compare against DEPTH-1 rather than wrapping, so non-power-of-2
        // depths finish on time.
        if (r_clr_idx == LAST_IDX) begin
          w_state_nxt   = RF_IDLE;
          w_clr_idx_nxt = '0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + AW'(1);
        end
      end
      default: begin
        w_state_nxt = RF_IDLE;
      end
    endcase
  end

  assign o_clear_busy = (r_state == RF_CLEAR);
  assign o_clr_idx    = r_clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with hardware clear
//
// Purpose : register file for the ID stage. It has one synchronous write port
//           and NUM_RD registered read ports with 1-cycle latency. A hardware
//           clear sequencer zeroes the array after reset or on request. Entry 0
//           can optionally be a hard-wired zero register.
// Config  : macro REGFILE_BYPASS_EN
//             defined   - a qualifying write to the address being read in the
//                         same cycle is forwarded to the read port (write-first).
//                         The zero register is never forwarded.
//             undefined - a same-cycle read returns the old value (read-first).
// Ports   :
//   i_clk        clock
//   i_rst        asynchronous active-high reset
//   i_rd_addr    NUM_RD read addresses, port i at [i*AW +: AW]
//   o_rd_data    NUM_RD registered read data, port i at [i*DW +: DW]
//   i_we         write enable
//   i_wr_addr    write address
//   i_wr_data    write data
//   i_clear_req  single-cycle pulse that starts a full clear
//   o_clear_busy high while the clear sequencer runs; writes are dropped

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW        = RF_DW_DEF,
  parameter int DEPTH     = RF_DEPTH_DEF,
  parameter int NUM_RD    = RF_NUM_RD_DEF,
  parameter int ZERO_REG0 = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  output logic [NUM_RD*DW-1:0] o_rd_data,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [DW-1:0]        i_wr_data,
  input  logic                 i_clear_req,
  output logic                 o_clear_busy
);

  localparam bit          ZR      = (ZERO_REG0 != 0);
  localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

  if (NUM_RD < 1 || NUM_RD > RF_NUM_RD_MAX || DEPTH < 2) begin : g_bad_cfg
    $error("regfile_mp: NUM_RD must be 1..4 and DEPTH >= 2");
  end

  // One extra bit so that DEPTH itself is representable when DEPTH == 2**AW.
  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_X);
  endfunction

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_clear_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_idx;
  logic          w_wr_hit;

  regfile_clear_fsm #(
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear_req  (i_clear_req),
    .o_clear_busy (w_clear_busy),
    .o_clr_we     (w_clr_we),
    .o_clr_idx    (w_clr_idx)
  );

  assign o_clear_busy = w_clear_busy;

  // A write takes effect only outside a clear, to an existing entry, and never
  // to the zero register.
  assign w_wr_hit = i_we && !w_clear_busy && in_range(i_wr_addr)
                    && !(ZR && (i_wr_addr == '0));

  // The array has no reset; the clear sequencer zeroes it. w_clr_we and
  // w_wr_hit are mutually exclusive because w_wr_hit requires !w_clear_busy.
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_hit) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_val;
    logic [DW-1:0] r_q;

    assign w_addr = i_rd_addr[gi*AW +: AW];

    always_comb begin
      w_val = '0;
      if (!in_range(w_addr)) begin
        w_val = '0;
      end else if (ZR && (w_addr == '0)) begin
        w_val = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (w_wr_hit && (i_wr_addr == w_addr)) begin
        w_val = i_wr_data;
`endif
      end else begin
        w_val = r_mem[w_addr];
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_q <= '0;
      end else begin
        r_q <= w_val;
      end
    end

    assign o_rd_data[gi*DW +: DW] = r_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp

module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Group A: two DEPTH=32, NUM_RD=2 instances sharing stimulus, ZERO_REG0 = 1 / 0
  logic        rst_a, we_a, clear_req_a;
  logic [9:0]  rd_addr_a;
  logic [4:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [63:0] rd_zr1, rd_zr0;
  logic        busy_zr1, busy_zr0;

  // Group B: DEPTH=24, NUM_RD=4
  logic         rst_b, we_b, clear_req_b;
  logic [19:0]  rd_addr_b;
  logic [4:0]   wr_addr_b;
  logic [31:0]  wr_data_b;
  logic [127:0] rd_b;
  logic         busy_b;

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG0(1)) u_zr1 (
    .i_clk(clk), .i_rst(rst_a), .i_rd_addr(rd_addr_a), .o_rd_data(rd_zr1),
    .i_we(we_a), .i_wr_addr(wr_addr_a), .i_wr_data(wr_data_a),
    .i_clear_req(clear_req_a), .o_clear_busy(busy_zr1));

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG0(0)) u_zr0 (
    .i_clk(clk), .i_rst(rst_a), .i_rd_addr(rd_addr_a), .o_rd_data(rd_zr0),
    .i_we(we_a), .i_wr_addr(wr_addr_a), .i_wr_data(wr_data_a),
    .i_clear_req(clear_req_a), .o_clear_busy(busy_zr0));

  regfile_mp #(.DW(32), .DEPTH(24), .NUM_RD(4), .ZERO_REG0(1)) u_d24 (
    .i_clk(clk), .i_rst(rst_b), .i_rd_addr(rd_addr_b), .o_rd_data(rd_b),
    .i_we(we_b), .i_wr_addr(wr_addr_b), .i_wr_data(wr_data_b),
    .i_clear_req(clear_req_b), .o_clear_busy(busy_b));

  int checks = 0;
  int errors = 0;

  // Reference contents: m[0] for the ZERO_REG0=0 instance, m[1] for ZERO_REG0=1.
  // X marks entries never written or cleared.
  logic [31:0] m [2][32];
  int          clr_left;  // clear cycles still to run; 0 means idle

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] z1_0;
    logic [31:0] z1_1;
    logic [31:0] z0_0;
    logic [31:0] z0_1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input int z, input logic [4:0] a, input bit busy_pre);
    if (z == 1 && a == 5'd0) return 32'h0;
    if (BYP && we_a && !busy_pre && a == wr_addr_a && !(z == 1 && wr_addr_a == 5'd0))
      return wr_data_a;
    return m[z][a];
  endfunction

  // One clock of group A: predict, update the model, clock, and compare.
  task automatic cycle_a(input string tag);
    logic [31:0] e [2][2];
    bit busy_pre;
    busy_pre = (clr_left > 0);
    for (int z = 0; z < 2; z++)
      for (int p = 0; p < 2; p++)
        e[z][p] = exp_rd(z, rd_addr_a[p*5 +: 5], busy_pre);
    if (busy_pre) begin
      m[0][32 - clr_left] = 32'h0;
      m[1][32 - clr_left] = 32'h0;
      clr_left--;
    end else begin
      if (clear_req_a) clr_left = 32;
      if (we_a) begin
        m[0][wr_addr_a] = wr_data_a;
        if (wr_addr_a != 5'd0) m[1][wr_addr_a] = wr_data_a;
      end
    end
    tick();
    for (int p = 0; p < 2; p++) begin
      if (!$isunknown(e[0][p]))
        chk($sformatf("%s_zr0_rd%0d", tag, p), rd_zr0[p*32 +: 32], e[0][p]);
      if (!$isunknown(e[1][p]))
        chk($sformatf("%s_zr1_rd%0d", tag, p), rd_zr1[p*32 +: 32], e[1][p]);
    end
    chk({tag, "_busy_zr1"}, busy_zr1, clr_left > 0);
    chk({tag, "_busy_zr0"}, busy_zr0, clr_left > 0);
  endtask

  initial begin
    int nb;
    rst_a = 1'b1; we_a = 1'b0; clear_req_a = 1'b0; rd_addr_a = '0;
    wr_addr_a = '0; wr_data_a = '0;
    rst_b = 1'b1; we_b = 1'b0; clear_req_b = 1'b0; rd_addr_b = '0;
    wr_addr_b = '0; wr_data_b = '0;
    clr_left = 32;

    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0,
                BYP ? 32'hDEADBEEF : 32'h0, 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
    vecs[1] = '{1'b1, 5'd0, 32'h00001234, 5'd5, 5'd0,
                32'hDEADBEEF, 32'h0, 32'hDEADBEEF, BYP ? 32'h00001234 : 32'h0};
    vecs[2] = '{1'b1, 5'd7, 32'h00000011, 5'd0, 5'd5,
                32'h0, 32'hDEADBEEF, 32'h00001234, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd3, 5'd7,
                32'h0, BYP ? 32'hA5A5A5A5 : 32'h11, 32'h0, BYP ? 32'hA5A5A5A5 : 32'h11};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7,
                32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd5,
                32'h0, 32'hDEADBEEF, 32'h00001234, 32'hDEADBEEF};

    // Reset state
    tick(); tick();
    chk("rst_rd_zr1", rd_zr1, 64'h0);
    chk("rst_rd_zr0", rd_zr0, 64'h0);
    chk("rst_busy", busy_zr1, 1'b1);
    rst_a = 1'b0;

    // Ten clear cycles with writes attempted, then reset at clr_idx=10
    for (int i = 0; i < 10; i++) begin
      we_a = 1'b1; wr_addr_a = 5'($urandom); wr_data_a = $urandom;
      rd_addr_a = 10'($urandom);
      cycle_a("clr1");
    end
    we_a = 1'b0;
    rst_a = 1'b1;
    #1;
    chk("midrst_busy", busy_zr1, 1'b1);
    chk("midrst_rd", rd_zr1, 64'h0);
    clr_left = 32;
    tick();
    rst_a = 1'b0;

    // Restarted clear must last exactly 32 cycles
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_zr1) nb++;
      rd_addr_a = 10'($urandom);
      cycle_a("clr2");
    end
    chk("clear_len_after_rst", nb, 32);

    for (int i = 0; i < 32; i++) begin
      rd_addr_a = {5'(31 - i), 5'(i)};
      cycle_a("zero_after_rst");
      chk($sformatf("zero_after_rst_%0d", i), {rd_zr1, rd_zr0}, 128'h0);
    end

    // Directed table: write/read latency, zero register, same-cycle hazard
    for (int i = 0; i < 6; i++) begin
      we_a = vecs[i].we; wr_addr_a = vecs[i].wa; wr_data_a = vecs[i].wd;
      rd_addr_a = {vecs[i].ra1, vecs[i].ra0};
      cycle_a("tbl_model");
      chk($sformatf("tbl%0d_zr1", i), rd_zr1, {vecs[i].z1_1, vecs[i].z1_0});
      chk($sformatf("tbl%0d_zr0", i), rd_zr0, {vecs[i].z0_1, vecs[i].z0_0});
    end
    we_a = 1'b0;

    // Fill 1..31, clear on request, write and re-request during the clear
    for (int i = 1; i < 32; i++) begin
      we_a = 1'b1; wr_addr_a = 5'(i); wr_data_a = $urandom | 32'h1;
      rd_addr_a = 10'($urandom);
      cycle_a("fill");
    end
    we_a = 1'b0; clear_req_a = 1'b1;
    cycle_a("clrreq");
    clear_req_a = 1'b0;
    for (int k = 0; k < 32; k++) begin
      we_a = (k == 2); wr_addr_a = 5'd3; wr_data_a = 32'hFFFFFFFF;
      clear_req_a = (k == 5);
      rd_addr_a = 10'($urandom);
      cycle_a("clr3");
    end
    we_a = 1'b0; clear_req_a = 1'b0;
    chk("clr3_done_busy", busy_zr1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = {5'(i), 5'd3};
      cycle_a("zero_after_req");
      chk($sformatf("zero_after_req_%0d", i), {rd_zr1, rd_zr0}, 128'h0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      we_a = 1'($urandom_range(0, 1));
      wr_addr_a = 5'($urandom);
      wr_data_a = $urandom;
      rd_addr_a[4:0] = 5'($urandom);
      rd_addr_a[9:5] = ($urandom_range(0, 3) == 0) ? wr_addr_a : 5'($urandom);
      clear_req_a = ($urandom_range(0, 59) == 0);
      cycle_a("rnd");
    end
    we_a = 1'b0; clear_req_a = 1'b0;

    // Group B: DEPTH=24, four ports, out-of-range addresses
    chk("d24_rst_rd", rd_b, 128'h0);
    chk("d24_rst_busy", busy_b, 1'b1);
    rst_b = 1'b0;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy_b) nb++;
      tick();
    end
    chk("d24_clear_len", nb, 24);
    we_b = 1'b1; wr_addr_b = 5'd23; wr_data_b = 32'hC0FFEE01; tick();
    wr_addr_b = 5'd5; wr_data_b = 32'h5A5A0005; tick();
    wr_addr_b = 5'd30; wr_data_b = 32'hFFFFFFFF; tick();
    we_b = 1'b0;
    rd_addr_b = {5'd24, 5'd5, 5'd23, 5'd30};
    tick();
    chk("d24_rd0_addr30", rd_b[31:0], 32'h0);
    chk("d24_rd1_addr23", rd_b[63:32], 32'hC0FFEE01);
    chk("d24_rd2_addr5", rd_b[95:64], 32'h5A5A0005);
    chk("d24_rd3_addr24", rd_b[127:96], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
